// File: rtl/dcache_req_arbiter.sv
// dcache_req_arbiter
// Shares the single D-cache request port between the EX-stage memory request
// and a held copy of the first missing load. A load miss starts a speculation
// episode. The held load is replayed to the cache until it returns, and the
// true value is then reported for verification. Pipeline accesses are stalled
// until the episode resolves or is flushed.

module dcache_req_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // EX-stage memory request
  input  logic                  pipe_valid,
  input  logic                  pipe_is_read,
  input  logic [ADDR_WIDTH-1:0] pipe_addr,
  input  logic [ADDR_WIDTH-1:0] pipe_addr_next,
  input  logic [DATA_WIDTH-1:0] pipe_wdata,
  output logic                  pipe_grant,
  output logic                  pipe_stall,
  // D-cache request port
  output logic                  dc_valid,
  output logic                  dc_is_read,
  output logic [ADDR_WIDTH-1:0] dc_addr,
  output logic [ADDR_WIDTH-1:0] dc_addr_next,
  output logic [DATA_WIDTH-1:0] dc_wdata,
  input  logic                  dc_rvalid,
  input  logic [DATA_WIDTH-1:0] dc_rdata,
  // Speculation episode control / status
  input  logic                  flush_spec,
  output logic                  spec_start,
  output logic                  spec_active,
  output logic                  spec_resolve,
  output logic [DATA_WIDTH-1:0] spec_data,
  output logic [CNT_WIDTH-1:0]  spec_cycles
);

  // Arbiter states. RELEASE lasts exactly one cycle after a resolve.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;

  // Held copy of the missing load
  logic                  r_hold_is_read;
  logic [ADDR_WIDTH-1:0] r_hold_addr;
  logic [ADDR_WIDTH-1:0] r_hold_addr_next;
  logic [DATA_WIDTH-1:0] r_hold_wdata;

  // Registered status outputs
  logic                  r_spec_start;
  logic                  r_spec_active;
  logic                  r_spec_resolve;
  logic [DATA_WIDTH-1:0] r_spec_data;
  logic [CNT_WIDTH-1:0]  r_spec_cycles;

  logic                  w_in_hold;
  logic                  w_capture;
  logic                  w_resolve;
  logic                  w_cnt_max;

  assign w_in_hold = (r_state == ST_HOLD);

  // Only a load miss in IDLE opens an episode. RELEASE suppresses capture, so
  // the load just resolved is not re-captured when the pipeline re-presents it.
  assign w_capture = (r_state == ST_IDLE) & pipe_valid & pipe_is_read & ~dc_rvalid;

  // Flush wins over a same-cycle return of the held load.
  assign w_resolve = w_in_hold & ~flush_spec & dc_rvalid;

  assign w_cnt_max = &r_spec_cycles;

  // Next-state selection for the episode FSM
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (flush_spec) begin
          w_state_nxt = ST_IDLE;
        end else if (dc_rvalid) begin
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Hold register, loaded only on capture and stable for the whole episode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_is_read   <= 1'b0;
      r_hold_addr      <= '0;
      r_hold_addr_next <= '0;
      r_hold_wdata     <= '0;
    end else if (w_capture) begin
      r_hold_is_read   <= pipe_is_read;
      r_hold_addr      <= pipe_addr;
      r_hold_addr_next <= pipe_addr_next;
      r_hold_wdata     <= pipe_wdata;
    end
  end

  // Episode pulses and activity flag, one cycle behind the triggering event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spec_start   <= 1'b0;
      r_spec_active  <= 1'b0;
      r_spec_resolve <= 1'b0;
    end else begin
      r_spec_start   <= w_capture;
      r_spec_active  <= (w_state_nxt == ST_HOLD);
      r_spec_resolve <= w_resolve;
    end
  end

  // True value of the held load, kept until the next resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spec_data <= '0;
    end else if (w_resolve) begin
      r_spec_data <= dc_rdata;
    end
  end

  // Saturating episode length: cleared on capture, counts every HOLD cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spec_cycles <= '0;
    end else if (w_capture) begin
      r_spec_cycles <= '0;
    end else if (w_in_hold && !w_cnt_max) begin
      r_spec_cycles <= r_spec_cycles + 1'b1;
    end
  end

  // Request port mux and pipeline handshake
  always_comb begin
    dc_valid     = pipe_valid;
    dc_is_read   = pipe_is_read;
    dc_addr      = pipe_addr;
    dc_addr_next = pipe_addr_next;
    dc_wdata     = pipe_wdata;
    pipe_grant   = pipe_valid & dc_rvalid;
    pipe_stall   = pipe_valid & ~dc_rvalid;
    if (w_in_hold) begin
      dc_valid     = 1'b1;
      dc_is_read   = r_hold_is_read;
      dc_addr      = r_hold_addr;
      dc_addr_next = r_hold_addr_next;
      dc_wdata     = r_hold_wdata;
      pipe_grant   = 1'b0;
      pipe_stall   = pipe_valid;
    end
  end

  assign spec_start   = r_spec_start;
  assign spec_active  = r_spec_active;
  assign spec_resolve = r_spec_resolve;
  assign spec_data    = r_spec_data;
  assign spec_cycles  = r_spec_cycles;

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// tb_dcache_req_arbiter
// Scoreboard bench: expected outputs for each cycle are queued when the
// stimulus is driven and compared when the DUT outputs are sampled mid-cycle.

module tb_dcache_req_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          clk_run;
  logic          rst_n;
  logic          pipe_valid;
  logic          pipe_is_read;
  logic [AW-1:0] pipe_addr;
  logic [AW-1:0] pipe_addr_next;
  logic [DW-1:0] pipe_wdata;
  logic          pipe_grant;
  logic          pipe_stall;
  logic          dc_valid;
  logic          dc_is_read;
  logic [AW-1:0] dc_addr;
  logic [AW-1:0] dc_addr_next;
  logic [DW-1:0] dc_wdata;
  logic          dc_rvalid;
  logic [DW-1:0] dc_rdata;
  logic          flush_spec;
  logic          spec_start;
  logic          spec_active;
  logic          spec_resolve;
  logic [DW-1:0] spec_data;
  logic [CW-1:0] spec_cycles;

  dcache_req_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipe_valid     (pipe_valid),
    .pipe_is_read   (pipe_is_read),
    .pipe_addr      (pipe_addr),
    .pipe_addr_next (pipe_addr_next),
    .pipe_wdata     (pipe_wdata),
    .pipe_grant     (pipe_grant),
    .pipe_stall     (pipe_stall),
    .dc_valid       (dc_valid),
    .dc_is_read     (dc_is_read),
    .dc_addr        (dc_addr),
    .dc_addr_next   (dc_addr_next),
    .dc_wdata       (dc_wdata),
    .dc_rvalid      (dc_rvalid),
    .dc_rdata       (dc_rdata),
    .flush_spec     (flush_spec),
    .spec_start     (spec_start),
    .spec_active    (spec_active),
    .spec_resolve   (spec_resolve),
    .spec_data      (spec_data),
    .spec_cycles    (spec_cycles)
  );

  // Gated clock so it can be stopped for the async reset case
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  int unsigned n_vec;
  int unsigned n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic          grant;
    logic          stall;
    logic          dv;
    logic          dr;
    logic [AW-1:0] da;
    logic [AW-1:0] dn;
    logic [DW-1:0] dw;
    logic          start;
    logic          active;
    logic          resolve;
    logic [DW-1:0] sdata;
    logic [CW-1:0] cyc;
  } exp_t;

  exp_t q[$];

  // Reference model of the arbiter (0 idle, 1 hold, 2 release)
  int            m_st;
  logic [AW-1:0] m_haddr;
  logic [AW-1:0] m_hnext;
  logic [DW-1:0] m_hwdata;
  logic          m_start;
  logic          m_active;
  logic          m_resolve;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_cyc;

  task automatic model_reset();
    m_st = 0; m_haddr = '0; m_hnext = '0; m_hwdata = '0;
    m_start = 0; m_active = 0; m_resolve = 0; m_data = '0; m_cyc = '0;
  endtask

  task automatic push_expect();
    exp_t e;
    if (m_st == 1) begin
      e.grant = 1'b0;        e.stall = pipe_valid;
      e.dv = 1'b1;           e.dr = 1'b1;
      e.da = m_haddr;        e.dn = m_hnext;  e.dw = m_hwdata;
    end else begin
      e.grant = pipe_valid & dc_rvalid;
      e.stall = pipe_valid & ~dc_rvalid;
      e.dv = pipe_valid;     e.dr = pipe_is_read;
      e.da = pipe_addr;      e.dn = pipe_addr_next; e.dw = pipe_wdata;
    end
    e.start = m_start; e.active = m_active; e.resolve = m_resolve;
    e.sdata = m_data;  e.cyc = m_cyc;
    q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (q.size() == 0) begin
      chk("queue_empty", 64'd1, 64'd0);
      return;
    end
    e = q.pop_front();
    chk("pipe_grant",   pipe_grant,   e.grant);
    chk("pipe_stall",   pipe_stall,   e.stall);
    chk("dc_valid",     dc_valid,     e.dv);
    chk("dc_is_read",   dc_is_read,   e.dr);
    chk("dc_addr",      dc_addr,      e.da);
    chk("dc_addr_next", dc_addr_next, e.dn);
    chk("dc_wdata",     dc_wdata,     e.dw);
    chk("spec_start",   spec_start,   e.start);
    chk("spec_active",  spec_active,  e.active);
    chk("spec_resolve", spec_resolve, e.resolve);
    chk("spec_data",    spec_data,    e.sdata);
    chk("spec_cycles",  spec_cycles,  e.cyc);
  endtask

  task automatic model_clock();
    bit cap;
    bit res;
    int nxt;
    cap = (m_st == 0) && pipe_valid && pipe_is_read && !dc_rvalid;
    res = (m_st == 1) && !flush_spec && dc_rvalid;
    case (m_st)
      0: nxt = cap ? 1 : 0;
      1: nxt = flush_spec ? 0 : (dc_rvalid ? 2 : 1);
      default: nxt = 0;
    endcase
    if (cap) begin
      m_haddr = pipe_addr; m_hnext = pipe_addr_next; m_hwdata = pipe_wdata;
      m_cyc = '0;
    end else if (m_st == 1 && m_cyc != {CW{1'b1}}) begin
      m_cyc = m_cyc + 1'b1;
    end
    if (res) m_data = dc_rdata;
    m_start = cap;
    m_resolve = res;
    m_active = (nxt == 1);
    m_st = nxt;
  endtask

  // One clock cycle: queue expectation, sample at negedge, advance at posedge
  task automatic tick();
    push_expect();
    @(negedge clk);
    compare_out();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic [AW-1:0] a,
                       input logic rv, input logic [DW-1:0] rdat, input logic fl);
    pipe_valid     = v;
    pipe_is_read   = rd;
    pipe_addr      = a;
    pipe_addr_next = a + 32'h40;
    pipe_wdata     = a ^ 32'hA5A5_0000;
    dc_rvalid      = rv;
    dc_rdata       = rdat;
    flush_spec     = fl;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clk_run = 1'b1;
    rst_n = 1'b0;
    drive(0, 0, '0, 0, '0, 0);
    model_reset();
    #12;
    // Reset state
    chk("rst_start",  spec_start,   0);
    chk("rst_active", spec_active,  0);
    chk("rst_cycles", spec_cycles,  0);
    chk("rst_data",   spec_data,    0);
    chk("rst_dcv",    dc_valid,     0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load hit in IDLE
    drive(1, 1, 32'h100, 1, 32'h1111, 0);
    tick();
    chk("hit_no_start", spec_start, 0);

    // Load miss to 0x200, returns on the 4th HOLD cycle
    drive(1, 1, 32'h200, 0, '0, 0);
    tick();
    drive(1, 0, 32'h300, 0, '0, 0);          // store during HOLD
    tick();
    drive(1, 1, 32'h300, 0, '0, 0);
    tick();
    drive(0, 0, 32'h300, 0, '0, 0);
    tick();
    drive(1, 1, 32'h300, 1, 32'hDEADBEEF, 0);
    tick();
    chk("resolve_pulse", spec_resolve, 1);
    chk("resolve_data",  spec_data,    32'hDEADBEEF);
    chk("episode_len",   spec_cycles,  4);

    // RELEASE: same load re-presented and missing does not capture
    drive(1, 1, 32'h200, 0, '0, 0);
    tick();
    chk("release_no_start", spec_start, 0);
    // One cycle later it captures
    tick();
    chk("recapture_start", spec_start, 1);

    // Flush and return in the same HOLD cycle
    drive(1, 1, 32'h200, 1, 32'h12345678, 1);
    tick();
    chk("flush_no_resolve", spec_resolve, 0);
    chk("flush_keep_data",  spec_data,    32'hDEADBEEF);
    // Next miss captures normally; flush in IDLE is ignored
    drive(1, 1, 32'h400, 0, '0, 1);
    tick();
    chk("post_flush_start", spec_start, 1);

    // Long episode: counter saturates
    drive(1, 0, 32'h480, 0, '0, 0);
    for (int i = 0; i < 18; i++) tick();
    chk("cycles_sat", spec_cycles, {CW{1'b1}});
    drive(0, 0, '0, 1, 32'hCAFEF00D, 0);
    tick();
    chk("sat_resolve_data", spec_data, 32'hCAFEF00D);
    drive(0, 0, '0, 0, '0, 0);
    tick();

    // Async reset mid-HOLD with the clock stopped
    drive(1, 1, 32'h600, 0, '0, 0);
    tick();
    drive(0, 0, '0, 0, '0, 0);
    tick();
    @(negedge clk);
    clk_run = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_active", spec_active,  0);
    chk("arst_dcv",    dc_valid,     0);
    chk("arst_dcaddr", dc_addr,      0);
    chk("arst_cycles", spec_cycles,  0);
    chk("arst_data",   spec_data,    0);
    chk("arst_stall",  pipe_stall,   0);
    model_reset();
    #6;
    rst_n = 1'b1;
    #2;
    clk_run = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 0, 32'h700, 0, '0, 0);
    tick();
    chk("store_miss_no_start", spec_start, 0);
    tick();
    drive(0, 0, '0, 0, '0, 0);
    tick();

    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
